ecc_dec_ctrl: RTL
=================

Name: ecc_dec_ctrl

Overview:
- Sequencing controller for the combinational syndrome/error-count unit of the EncDec decoder path.
- Accepts one codeword per transaction over a valid/ready handshake and registers it.
- Drives the registered codeword, parity and width strobes (Small/Medium) to the syndrome unit, samples its NOF/NOE results, and corrects a single-bit error.
- Returns corrected data plus error count downstream over a second valid/ready handshake.

Parameters:
- DATA_W, 32, codeword data width presented to the syndrome unit.
- PAR_W, 5, parity width (Yin).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream codeword valid.
- in_ready  output  1  controller can accept a codeword.
- in_data  input  DATA_W  received codeword data.
- in_parity  input  PAR_W  received parity (to Yin).
- in_width  input  2  CODEWORD_WIDTH: 00 small, 01 medium, 10 large, 11 illegal.
- dec_data  output  DATA_W  registered codeword to syndrome unit DATA_IN.
- dec_yin  output  PAR_W  registered parity to syndrome unit Yin.
- dec_small  output  1  Small strobe.
- dec_medium  output  1  Medium strobe.
- dec_nof  input  2  NOF from syndrome unit (01 single, 10 double, 00 none).
- dec_noe  input  5  NOE_Out error index from syndrome unit.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  DATA_W  corrected data.
- out_nof  output  2  error status: 00 clean, 01 corrected, 10 uncorrectable, 11 illegal width.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- States: IDLE, CHECK, FIX, OUT. The encoding is an implementation choice.
- Reset (synchronous, rst=1 at a clk edge): state goes to IDLE; in_ready=1; out_valid=0; busy=0; out_data, out_nof, dec_data and dec_yin = 0; dec_small=0; dec_medium=0.
- Reset mid-transaction discards the in-flight codeword. No output handshake completes in that cycle.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_data→dec_data and in_parity→dec_yin.
  - Decode in_width: 00 → dec_small=1, dec_medium=0; 01 → dec_medium=1, dec_small=0; 10 or 11 → both 0.
  - Transition to CHECK.
- CHECK:
  - in_ready=0. The syndrome unit is combinational, so its outputs are settled on the registered inputs.
  - Register dec_nof and dec_noe into internal nof_q and noe_q.
  - Transition to FIX.
- FIX: compute the result, then transition to OUT.
  - Width 11: out_data=dec_data, out_nof=11, no correction.
  - nof_q=01 and noe_q≠0: out_data = dec_data with bit (noe_q−1) inverted; out_nof=01.
  - nof_q=01 and noe_q=0: parity-bit-only error; data unchanged; out_nof=01.
  - If noe_q−1 ≥ DATA_W, data is unchanged; out_nof=01.
  - nof_q=10: data unchanged; out_nof=10.
  - nof_q=00: data unchanged; out_nof=00.
  - nof_q=11 is impossible from the syndrome unit; treat it as 10.
- OUT:
  - out_valid=1. out_data and out_nof are held stable until out_ready.
  - On out_valid&out_ready: out_valid falls next cycle and state returns to IDLE.
  - in_ready is 0 in OUT. There is no overlap, so the throughput is one codeword per ≥4 cycles.
- Latency: accept edge → out_valid high after 3 clk edges (IDLE→CHECK→FIX→OUT).
- Backpressure: out_ready low holds OUT indefinitely, and in_ready stays low.
- dec_* outputs hold their values from accept until the next accept. They are not cleared on return to IDLE.
- busy = (state≠IDLE).

Optional Feature:
- Macro: ECC_DEC_STATS_EN.
- When defined, three additional output ports (CNT_W each) are added: stat_total, stat_corr, stat_uncorr. The counters behave as follows:
  - Reset to 0.
  - Each increments on the OUT handshake cycle: total always; corr when out_nof=01; uncorr when out_nof=10 or 11.
  - Each saturates at all-ones; no wrap.
  - stat_clr input (1 bit) zeroes all three synchronously. If stat_clr coincides with a handshake, the clear wins.
- When not defined, none of these ports or registers exist, and the behaviour is otherwise identical.

Test Plan:
- Reset, then idle → in_ready=1, out_valid=0, busy=0, dec_small=dec_medium=0, all data outputs 0.
- Large (10) codeword with syndrome model returning nof=01, noe=5, in_data=32'h0000_00F0 → out_valid on the 3rd edge after accept; out_data=32'h0000_00E0 (bit 4 flipped); out_nof=01.
- Small (00) codeword, model nof=00 → dec_small=1, dec_medium=0 during CHECK; out_data=in_data; out_nof=00.
- Medium (01), model nof=10 → out_nof=10, data unchanged; out_ready held low 5 cycles → out_valid/out_data stable, in_ready=0 throughout, then accepted and returned to IDLE.
- in_width=11 → out_nof=11, data unchanged, both strobes 0. Assert rst in FIX on a second transaction → next cycle IDLE, out_valid=0, no output handshake.
- With ECC_DEC_STATS_EN: 3 transactions (clean, corrected, uncorrectable) → stat_total=3, stat_corr=1, stat_uncorr=1; stat_clr coincident with a 4th handshake → all 0.

Source files
------------

// File: rtl/ecc_dec_ctrl.sv
// Sequencing controller around the combinational syndrome/error-count unit:
// accept codeword, present it, sample NOF/NOE, fix one bit, hand result on.
// Optional statistics counters are enabled with the ECC_DEC_STATS_EN macro.
module ecc_dec_ctrl #(
    parameter int DATA_W = 32,
    parameter int PAR_W  = 5
`ifdef ECC_DEC_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PAR_W-1:0]  in_parity,
    input  logic [1:0]        in_width,
    output logic [DATA_W-1:0] dec_data,
    output logic [PAR_W-1:0]  dec_yin,
    output logic              dec_small,
    output logic              dec_medium,
    input  logic [1:0]        dec_nof,
    input  logic [4:0]        dec_noe,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_nof,
    output logic              busy
`ifdef ECC_DEC_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_total,
    output logic [CNT_W-1:0]  stat_corr,
    output logic [CNT_W-1:0]  stat_uncorr
`endif
);

    typedef enum logic [1:0] {IDLE, CHECK, FIX, OUT} state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_dec_data;
    logic [PAR_W-1:0]  r_dec_yin;
    logic              r_small;
    logic              r_medium;
    logic              r_width_ill;
    logic [1:0]        r_nof_q;
    logic [4:0]        r_noe_q;
    logic [DATA_W-1:0] r_out_data;
    logic [1:0]        r_out_nof;

    logic [DATA_W-1:0] w_flip_mask;
    logic [DATA_W-1:0] w_fix_data;
    logic [1:0]        w_fix_nof;

    // NOE is 1-based; index 0 (parity-only) and out-of-range indices match no bit.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_flip
            assign w_flip_mask[gi] = (32'(r_noe_q) == 32'(gi + 1));
        end
    endgenerate

    always_comb begin
        w_fix_data = r_dec_data;
        w_fix_nof  = 2'b00;
        if (r_width_ill) begin
            w_fix_nof = 2'b11;
        end else begin
            case (r_nof_q)
                2'b00: w_fix_nof = 2'b00;
                2'b01: begin
                    w_fix_data = r_dec_data ^ w_flip_mask;
                    w_fix_nof  = 2'b01;
                end
                default: w_fix_nof = 2'b10;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_dec_data  <= '0;
            r_dec_yin   <= '0;
            r_small     <= 1'b0;
            r_medium    <= 1'b0;
            r_width_ill <= 1'b0;
            r_nof_q     <= 2'b00;
            r_noe_q     <= 5'd0;
            r_out_data  <= '0;
            r_out_nof   <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_dec_data  <= in_data;
                        r_dec_yin   <= in_parity;
                        r_small     <= (in_width == 2'b00);
                        r_medium    <= (in_width == 2'b01);
                        r_width_ill <= (in_width == 2'b11);
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= CHECK;
                    end
                end
                CHECK: begin
                    r_nof_q <= dec_nof;
                    r_noe_q <= dec_noe;
                    r_state <= FIX;
                end
                FIX: begin
                    r_out_data  <= w_fix_data;
                    r_out_nof   <= w_fix_nof;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_nof    = r_out_nof;
    assign dec_data   = r_dec_data;
    assign dec_yin    = r_dec_yin;
    assign dec_small  = r_small;
    assign dec_medium = r_medium;

`ifdef ECC_DEC_STATS_EN
    logic [CNT_W-1:0] r_stat_total;
    logic [CNT_W-1:0] r_stat_corr;
    logic [CNT_W-1:0] r_stat_uncorr;
    logic             w_hs;

    assign w_hs = (r_state == OUT) && r_out_valid && out_ready;

    // Clear has priority over a coincident handshake; counters saturate.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_stat_total  <= '0;
            r_stat_corr   <= '0;
            r_stat_uncorr <= '0;
        end else if (w_hs) begin
            if (!(&r_stat_total))
                r_stat_total <= r_stat_total + CNT_W'(1);
            if ((r_out_nof == 2'b01) && !(&r_stat_corr))
                r_stat_corr <= r_stat_corr + CNT_W'(1);
            if (r_out_nof[1] && !(&r_stat_uncorr))
                r_stat_uncorr <= r_stat_uncorr + CNT_W'(1);
        end
    end

    assign stat_total  = r_stat_total;
    assign stat_corr   = r_stat_corr;
    assign stat_uncorr = r_stat_uncorr;
`endif

endmodule
